// File: rtl/ibex_vrf_group_writer.sv
// ibex_vrf_group_writer
//
// Vector register file with a multi-beat register-group write sequencer.
// A group write of LMUL registers (LMUL = 1/2/4/8) arrives as LMUL beats of
// VLEN bits on a valid/ready channel.  One register is committed per accepted
// beat, under per-byte enables.  NRD combinational read ports report a hazard
// while they address a register of the active group that is not yet written.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active high (clears every register)
//   vlmul_i      group size code, sampled on the first beat (000=1 .. 011=8)
//   wr_valid_i   write beat valid
//   wr_ready_o   write beat ready (low during reset or flush)
//   wr_addr_i    group base register, sampled on the first beat only
//   wr_data_i    beat data
//   wr_be_i      per-byte write enable for this beat
//   wr_flush_i   abort the group in progress
//   wr_busy_o    a group is in progress
//   wr_done_o    one-cycle pulse: group completed
//   wr_err_o     one-cycle pulse: group rejected
//   rd_addr_i    read addresses, port p at [p*AW +: AW]
//   rd_data_o    read data, port p at [p*VLEN +: VLEN]
//   rd_hazard_o  port p addresses a pending register of the active group

module ibex_vrf_group_writer #(
    parameter int VLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 3,
    parameter int MAX_LMUL = 8,
    parameter int ZERO_V0  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [2:0]                    vlmul_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [$clog2(NREG)-1:0]       wr_addr_i,
    input  logic [VLEN-1:0]               wr_data_i,
    input  logic [VLEN/8-1:0]             wr_be_i,
    input  logic                          wr_flush_i,
    output logic                          wr_busy_o,
    output logic                          wr_done_o,
    output logic                          wr_err_o,
    input  logic [NRD*$clog2(NREG)-1:0]   rd_addr_i,
    output logic [NRD*VLEN-1:0]           rd_data_o,
    output logic [NRD-1:0]                rd_hazard_o
);

    localparam int AW = $clog2(NREG);
    localparam int NB = VLEN / 8;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   grp_addr;
    logic [3:0]      len_in;
    logic [31:0]     len_ext;
    logic [31:0]     base_ext;
    logic            bad_group;

    logic [VLEN-1:0] regs [NREG];

    assign wr_ready_o = ~rst_i & ~wr_flush_i;
    assign accept     = wr_valid_i & wr_ready_o;
    assign wr_busy_o  = (state_q == ACTIVE);
    assign wr_done_o  = done_q;
    assign wr_err_o   = err_q;

    // First-beat decode: the group length and whether the group is legal.
    // Alignment is a mask test because len is always a power of two.
    assign len_in    = 4'd1 << vlmul_i[1:0];
    assign len_ext   = {28'd0, len_in};
    assign base_ext  = 32'(wr_addr_i);
    assign bad_group = vlmul_i[2]
                     | (len_ext > 32'(MAX_LMUL))
                     | ((base_ext & (len_ext - 32'd1)) != 32'd0);

    // Register targeted by an ACTIVE beat; alignment rules out any wrap.
    assign grp_addr  = base_q + AW'(cnt_q);

    // State register plus the group bookkeeping and the registered pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= 4'd1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: decides which register (if any) this cycle's beat
    // writes, and which pulse fires on the following cycle.  Flush only has
    // an effect in ACTIVE; in IDLE it merely holds ready low.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = grp_addr;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_group) begin
                        err_d = 1'b1;
                    end else begin
                        we     = 1'b1;
                        waddr  = wr_addr_i;
                        base_d = wr_addr_i;
                        len_d  = len_in;
                        if (len_in == 4'd1) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = ACTIVE;
                        end
                    end
                end
            end
            ACTIVE: begin
                if (wr_flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    we = 1'b1;
                    if (cnt_q == len_q - 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register array.  Reset wipes every register.  With ZERO_V0 set a beat
    // aimed at v0 is still consumed by the sequencer but never stored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (we && !((ZERO_V0 != 0) && (waddr == '0))) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be_i[b]) begin
                    regs[waddr][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read ports: plain combinational reads with no write bypass.  A hazard
    // covers the still-pending window [base+cnt, base+len-1] of the group.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic [31:0]   ra_ext;
        logic [31:0]   lo;
        logic [31:0]   hi;

        assign ra     = rd_addr_i[p*AW +: AW];
        assign ra_ext = 32'(ra);
        assign lo     = 32'(base_q) + 32'(cnt_q);
        assign hi     = 32'(base_q) + 32'(len_q) - 32'd1;

        assign rd_data_o[p*VLEN +: VLEN] =
            ((ZERO_V0 != 0) && (ra == '0)) ? '0 : regs[ra];
        assign rd_hazard_o[p] = wr_busy_o & (ra_ext >= lo) & (ra_ext <= hi);
    end

endmodule

// File: tb/tb_ibex_vrf_group_writer.sv
// Testbench for ibex_vrf_group_writer.
// dut0 uses the default parameters; dut1 uses MAX_LMUL=4 and ZERO_V0=1.
// Both share every input, so each directed sequence exercises both variants.

module tb_ibex_vrf_group_writer;

    localparam int VLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int AW   = 5;

    logic               clk;
    logic               rst;
    logic [2:0]         vlmul;
    logic               wr_valid;
    logic [AW-1:0]      wr_addr;
    logic [VLEN-1:0]    wr_data;
    logic [3:0]         wr_be;
    logic               wr_flush;
    logic [AW-1:0]      rd_addr [NRD];
    logic [NRD*AW-1:0]  rd_addr_bus;

    logic               ready0, busy0, done0, err0;
    logic [NRD*VLEN-1:0] rdata0;
    logic [NRD-1:0]     haz0;
    logic               ready1, busy1, done1, err1;
    logic [NRD*VLEN-1:0] rdata1;
    logic [NRD-1:0]     haz1;

    int tests_run;
    int tests_failed;

    assign rd_addr_bus = {rd_addr[2], rd_addr[1], rd_addr[0]};

    ibex_vrf_group_writer #(
        .VLEN(VLEN), .NREG(NREG), .NRD(NRD), .MAX_LMUL(8), .ZERO_V0(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .vlmul_i(vlmul),
        .wr_valid_i(wr_valid), .wr_ready_o(ready0), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_flush_i(wr_flush),
        .wr_busy_o(busy0), .wr_done_o(done0), .wr_err_o(err0),
        .rd_addr_i(rd_addr_bus), .rd_data_o(rdata0), .rd_hazard_o(haz0)
    );

    ibex_vrf_group_writer #(
        .VLEN(VLEN), .NREG(NREG), .NRD(NRD), .MAX_LMUL(4), .ZERO_V0(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .vlmul_i(vlmul),
        .wr_valid_i(wr_valid), .wr_ready_o(ready1), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_flush_i(wr_flush),
        .wr_busy_o(busy1), .wr_done_o(done1), .wr_err_o(err1),
        .rd_addr_i(rd_addr_bus), .rd_data_o(rdata1), .rd_hazard_o(haz1)
    );

    // One record per clock cycle: inputs driven before the edge, the
    // sequencer outputs of dut0 expected just after it.
    typedef struct {
        logic          valid;
        logic [2:0]    vlmul;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic          flush;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_err;
    } vec_t;

    vec_t vecs [8];

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one observed value against the bench's expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Moves to 1 time unit after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives all write-side inputs for the coming cycle.
    task automatic applyStimulus(input logic v, input logic [2:0] lm,
                                 input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] be, input logic fl);
        wr_valid = v;
        vlmul    = lm;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        wr_flush = fl;
    endtask

    // Reads one register through a port of the chosen DUT and checks it.
    task automatic checkReg(input string name, input int dut, input int port,
                            input int r, input logic [31:0] expected);
        rd_addr[port] = AW'(r);
        #1;
        if (dut == 0)
            checkOutput(name, rdata0[port*VLEN +: VLEN], expected);
        else
            checkOutput(name, rdata1[port*VLEN +: VLEN], expected);
    endtask

    // Idle for 0..2 random cycles, then present one beat for one cycle.
    task automatic sendBeat(input logic [2:0] lm, input logic [AW-1:0] a,
                            input logic [31:0] d);
        int gaps;
        gaps = $urandom_range(0, 2);
        applyStimulus(1'b0, lm, a, d, 4'hF, 1'b0);
        repeat (gaps) stepCycle();
        applyStimulus(1'b1, lm, a, d, 4'hF, 1'b0);
        stepCycle();
        wr_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        rd_addr[0]   = '0;
        rd_addr[1]   = '0;
        rd_addr[2]   = '0;
        applyStimulus(1'b0, 3'd0, '0, '0, 4'h0, 1'b0);

        vecs[0] = '{1'b1, 3'd2, 5'd4, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'd2, 5'd0, 32'h22222222, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 3'd2, 5'd0, 32'h33333333, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 3'd2, 5'd0, 32'h44444444, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 5'd0, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3'd1, 5'd3, 32'h99999999, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 3'd4, 5'd0, 32'h88888888, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 3'd0, 5'd0, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state: every register reads zero on every port.
        repeat (3) stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("reset busy", 32'(busy0), 32'd0);
        checkOutput("reset done", 32'(done0), 32'd0);
        checkOutput("reset err", 32'(err0), 32'd0);
        checkOutput("reset ready", 32'(ready0), 32'd1);
        for (int r = 0; r < NREG; r++) begin
            for (int p = 0; p < NRD; p++) begin
                checkReg("reset reg", 0, p, r, 32'h0);
            end
        end

        // Four-register group at v4, then two rejected groups.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].vlmul, vecs[i].addr,
                          vecs[i].data, vecs[i].be, vecs[i].flush);
            stepCycle();
            checkOutput($sformatf("vec%0d busy", i), 32'(busy0), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d done", i), 32'(done0), 32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d err", i), 32'(err0), 32'(vecs[i].exp_err));
        end
        checkReg("group v4", 0, 0, 4, 32'h11111111);
        checkReg("group v5", 0, 1, 5, 32'h22222222);
        checkReg("group v6", 0, 2, 6, 32'h33333333);
        checkReg("group v7", 0, 0, 7, 32'h44444444);
        checkReg("err v3 untouched", 0, 1, 3, 32'h0);

        // vlmul=011 is legal for dut0 but too large for dut1 (MAX_LMUL=4).
        applyStimulus(1'b1, 3'd3, 5'd16, 32'hCAFECAFE, 4'h0, 1'b0);
        stepCycle();
        checkOutput("lmul8 dut0 busy", 32'(busy0), 32'd1);
        checkOutput("lmul8 dut0 err", 32'(err0), 32'd0);
        checkOutput("lmul8 dut1 err", 32'(err1), 32'd1);
        checkOutput("lmul8 dut1 busy", 32'(busy1), 32'd0);
        applyStimulus(1'b0, 3'd0, '0, '0, 4'h0, 1'b1);
        #1;
        checkOutput("flush ready", 32'(ready0), 32'd0);
        stepCycle();
        wr_flush = 1'b0;
        checkOutput("lmul8 flush busy", 32'(busy0), 32'd0);
        checkOutput("lmul8 flush done", 32'(done0), 32'd0);

        // Hazard window after the first beat of a group at v8, then flush.
        applyStimulus(1'b1, 3'd2, 5'd8, 32'hDEADBEEF, 4'hF, 1'b0);
        stepCycle();
        wr_valid   = 1'b0;
        rd_addr[0] = 5'd9;
        rd_addr[1] = 5'd8;
        rd_addr[2] = 5'd11;
        #1;
        checkOutput("hazard v9/v8/v11", 32'(haz0), 32'b101);
        // The beat presented together with flush must not land in v9.
        applyStimulus(1'b1, 3'd2, 5'd0, 32'h12345678, 4'hF, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 3'd0, '0, '0, 4'h0, 1'b0);
        checkOutput("flush busy", 32'(busy0), 32'd0);
        checkOutput("flush no done", 32'(done0), 32'd0);
        checkOutput("flush hazard", 32'(haz0), 32'b000);
        checkReg("flush v8 kept", 0, 0, 8, 32'hDEADBEEF);
        checkReg("flush v9", 0, 1, 9, 32'h0);
        checkReg("flush v10", 0, 2, 10, 32'h0);
        checkReg("flush v11", 0, 0, 11, 32'h0);

        // Byte-masked overwrite of v2.
        applyStimulus(1'b1, 3'd0, 5'd2, 32'hAABBCCDD, 4'hF, 1'b0);
        stepCycle();
        checkOutput("v2 first done", 32'(done0), 32'd1);
        applyStimulus(1'b1, 3'd0, 5'd2, 32'h11223344, 4'b0101, 1'b0);
        stepCycle();
        wr_valid = 1'b0;
        checkOutput("v2 mask done", 32'(done0), 32'd1);
        checkReg("v2 masked", 0, 0, 2, 32'hAA22CC44);

        // Write to v0: stored by dut0, dropped (but completed) by dut1.
        applyStimulus(1'b1, 3'd0, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
        stepCycle();
        wr_valid = 1'b0;
        checkOutput("v0 dut0 done", 32'(done0), 32'd1);
        checkOutput("v0 dut1 done", 32'(done1), 32'd1);
        checkReg("v0 dut0", 0, 0, 0, 32'hFFFFFFFF);
        checkReg("v0 dut1 zero", 1, 0, 0, 32'h0);

        // Reset in the middle of a group with random valid gaps.
        sendBeat(3'd1, 5'd2, 32'h55555555);
        checkOutput("pre-reset busy", 32'(busy0), 32'd1);
        repeat ($urandom_range(0, 2)) stepCycle();
        applyStimulus(1'b1, 3'd1, 5'd2, 32'h66666666, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("reset ready low", 32'(ready0), 32'd0);
        stepCycle();
        rst      = 1'b0;
        wr_valid = 1'b0;
        checkOutput("mid reset busy", 32'(busy0), 32'd0);
        checkOutput("mid reset done", 32'(done0), 32'd0);
        for (int r = 0; r < NREG; r++) begin
            checkReg("mid reset dut0", 0, 0, r, 32'h0);
            checkReg("mid reset dut1", 1, 1, r, 32'h0);
        end

        // Fresh group after reset starts from beat 0.
        sendBeat(3'd1, 5'd2, 32'hA0A0A0A0);
        checkOutput("regroup busy", 32'(busy0), 32'd1);
        checkOutput("regroup early done", 32'(done0), 32'd0);
        sendBeat(3'd0, 5'd20, 32'hB0B0B0B0);
        checkOutput("regroup done", 32'(done0), 32'd1);
        checkOutput("regroup idle", 32'(busy0), 32'd0);
        checkReg("regroup v2", 0, 0, 2, 32'hA0A0A0A0);
        checkReg("regroup v3", 0, 1, 3, 32'hB0B0B0B0);
        checkReg("regroup v20", 0, 2, 20, 32'h0);
        stepCycle();
        checkOutput("done single pulse", 32'(done0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
